// File: rtl/udp_rx_dispatch.sv
// UDP receive stage: parses the 8-byte header, matches the destination port against
// CH_N configured ports and steers the beat-aligned payload to one channel.
module udp_rx_dispatch #(
    parameter int                     DATA_W = 16,
    parameter int                     KEEP_W = DATA_W / 8,
    parameter int                     LEN_W  = $clog2(KEEP_W),
    parameter int                     CH_N   = 2,
    parameter int                     PORT_W = 16,
    parameter logic [CH_N*PORT_W-1:0] PORTS  = {16'd6000, 16'd5000}
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              cancel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ip_cs_err_i,
    output logic [CH_N-1:0]   valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [CH_N-1:0]   cancel_o,
    output logic              miss_o
);

    localparam int HDR_BEATS = 8 / KEEP_W;
    localparam int CH_W      = (CH_N > 1) ? $clog2(CH_N) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [63:0]         hdr_q, hdr_d;
    logic [15:0]         remain_q, remain_d;
    logic [15:0]         need_q, need_d;
    logic [15:0]         rcv_q, rcv_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                err_q, err_d;
    logic                emitted_q, emitted_d;
    logic                cancelled_q, cancelled_d;
    logic [CH_N-1:0]     valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CH_N-1:0]     cancel_q, cancel_d;
    logic                miss_q, miss_d;

    logic [DATA_W+63:0]  hdr_sh;
    logic [63:0]         hdr_full;
    logic [15:0]         dst_port;
    logic [15:0]         udp_len;
    logic                hit;
    logic [CH_W-1:0]     hit_idx;
    logic                hdr_beat, hdr_last, hdr_go;
    logic                abort, pay_beat, pay_final, pkt_end;
    logic [15:0]         beat_bytes;
    logic [CH_N-1:0]     ch_onehot;
    logic                unused_hdr;

    // The newest beat enters at the top so the complete header is visible on its last beat.
    assign hdr_sh     = {data_i, hdr_q};
    assign hdr_full   = hdr_sh[DATA_W +: 64];
    assign dst_port   = {hdr_full[23:16], hdr_full[31:24]};
    assign udp_len    = {hdr_full[39:32], hdr_full[47:40]};
    assign unused_hdr = ^{hdr_full[15:0], hdr_full[63:48], hdr_sh[DATA_W-1:0]};

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (PORTS[i*PORT_W +: PORT_W] == PORT_W'(dst_port)) begin
                hit     = 1'b1;
                hit_idx = CH_W'(i);
            end
        end
    end

    assign hdr_beat   = valid_i && (state_q == IDLE || state_q == HDR);
    assign hdr_last   = hdr_beat && (hdr_cnt_q == 2'(HDR_BEATS - 1));
    assign hdr_go     = hit && (udp_len > 16'd8);
    assign abort      = valid_i && cancel_i && (state_q != IDLE);
    assign pay_beat   = valid_i && !cancel_i && (state_q == PAYLOAD);
    assign pay_final  = pay_beat && (remain_q <= 16'(KEEP_W));
    assign pkt_end    = !valid_i && (state_q != IDLE);
    assign beat_bytes = (len_i == '0) ? 16'(KEEP_W) : 16'(len_i);
    assign ch_onehot  = CH_N'(1) << ch_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (hdr_last) state_d = hdr_go ? PAYLOAD : DRAIN;
                    else          state_d = HDR;
                end
            end
            HDR: begin
                if (!valid_i)      state_d = IDLE;
                else if (abort)    state_d = DRAIN;
                else if (hdr_last) state_d = hdr_go ? PAYLOAD : DRAIN;
            end
            PAYLOAD: begin
                if (!valid_i)                state_d = IDLE;
                else if (abort || pay_final) state_d = DRAIN;
            end
            DRAIN: begin
                if (!valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_cnt_d   = hdr_cnt_q;
        hdr_d       = hdr_q;
        remain_d    = remain_q;
        need_d      = need_q;
        rcv_d       = rcv_q;
        ch_d        = ch_q;
        err_d       = err_q;
        emitted_d   = emitted_q;
        cancelled_d = cancelled_q;
        data_d      = data_q;
        len_d       = len_q;
        valid_d     = '0;
        cancel_d    = '0;
        miss_d      = 1'b0;

        if (state_q == IDLE) begin
            hdr_cnt_d   = '0;
            rcv_d       = '0;
            err_d       = 1'b0;
            emitted_d   = 1'b0;
            cancelled_d = 1'b0;
        end
        if (valid_i && ip_cs_err_i) err_d = 1'b1;
        if (hdr_beat) begin
            hdr_d     = hdr_full;
            hdr_cnt_d = hdr_cnt_q + 2'd1;
        end
        if (hdr_last && !abort) begin
            need_d   = udp_len - 16'd8;
            remain_d = udp_len - 16'd8;
            ch_d     = hit_idx;
            if (udp_len < 16'd8) err_d  = 1'b1;
            else if (!hit)       miss_d = 1'b1;
        end
        if (valid_i && (state_q == PAYLOAD || state_q == DRAIN)) rcv_d = rcv_q + beat_bytes;
        // Only one cancel per packet, and only once the consumer has seen data.
        if (abort) begin
            err_d = 1'b1;
            if (state_q == PAYLOAD && emitted_q && !cancelled_q) begin
                cancel_d    = ch_onehot;
                cancelled_d = 1'b1;
            end
        end
        if (pay_beat) begin
            valid_d   = ch_onehot;
            data_d    = data_i;
            emitted_d = 1'b1;
            if (remain_q > 16'(KEEP_W)) begin
                len_d    = '0;
                remain_d = remain_q - 16'(KEEP_W);
            end else begin
                len_d = remain_q[LEN_W-1:0];
            end
        end
        if (pkt_end && emitted_q && !cancelled_q && (err_q || rcv_q < need_q)) cancel_d = ch_onehot;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hdr_cnt_q   <= '0;
            hdr_q       <= '0;
            remain_q    <= '0;
            need_q      <= '0;
            rcv_q       <= '0;
            ch_q        <= '0;
            err_q       <= 1'b0;
            emitted_q   <= 1'b0;
            cancelled_q <= 1'b0;
            valid_q     <= '0;
            data_q      <= '0;
            len_q       <= '0;
            cancel_q    <= '0;
            miss_q      <= 1'b0;
        end else begin
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_q       <= hdr_d;
            remain_q    <= remain_d;
            need_q      <= need_d;
            rcv_q       <= rcv_d;
            ch_q        <= ch_d;
            err_q       <= err_d;
            emitted_q   <= emitted_d;
            cancelled_q <= cancelled_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            len_q       <= len_d;
            cancel_q    <= cancel_d;
            miss_q      <= miss_d;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign len_o    = len_q;
    assign cancel_o = cancel_q;
    assign miss_o   = miss_q;

endmodule

// File: tb/tb_udp_rx_dispatch.sv
// Directed bench for udp_rx_dispatch (DATA_W=16, CH_N=2, ports {6000,5000}).
module tb_udp_rx_dispatch;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        valid_i = 1'b0;
    logic        cancel_i = 1'b0;
    logic [15:0] data_i = '0;
    logic [0:0]  len_i = '0;
    logic        ip_cs_err_i = 1'b0;
    logic [1:0]  valid_o;
    logic [15:0] data_o;
    logic [0:0]  len_o;
    logic [1:0]  cancel_o;
    logic        miss_o;

    udp_rx_dispatch #(
        .DATA_W(16), .KEEP_W(2), .LEN_W(1), .CH_N(2), .PORT_W(16),
        .PORTS({16'd6000, 16'd5000})
    ) dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .cancel_i(cancel_i),
        .data_i(data_i), .len_i(len_i), .ip_cs_err_i(ip_cs_err_i),
        .valid_o(valid_o), .data_o(data_o), .len_o(len_o),
        .cancel_o(cancel_o), .miss_o(miss_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, cleared whenever a new packet id is announced.
    int          pkt_id = 0;
    int          seen_id = 0;
    int          v_cnt, v_first, c_cnt, c_cyc, m_cnt, m_cyc, both_cnt;
    logic [1:0]  v_ch, c_val;
    logic [15:0] mdata [0:7];
    logic [0:0]  mlen  [0:7];

    always @(negedge clk) begin
        if (pkt_id != seen_id) begin
            seen_id <= pkt_id;
            v_cnt <= 0; v_first <= 0; c_cnt <= 0; c_cyc <= 0;
            m_cnt <= 0; m_cyc <= 0; v_ch <= '0; c_val <= '0;
        end else begin
            if (valid_o != '0) begin
                if (v_cnt == 0) v_first <= cyc;
                if (v_cnt < 8) begin
                    mdata[v_cnt] <= data_o;
                    mlen[v_cnt]  <= len_o;
                end
                v_cnt <= v_cnt + 1;
                v_ch  <= v_ch | valid_o;
            end
            if (cancel_o != '0) begin
                c_cnt <= c_cnt + 1;
                c_cyc <= cyc;
                c_val <= cancel_o;
            end
            if (miss_o) begin
                m_cnt <= m_cnt + 1;
                m_cyc <= cyc;
            end
            if (valid_o != '0 && cancel_o != '0) both_cnt <= both_cnt + 1;
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic l,
                         input logic c, input logic e);
        @(posedge clk);
        #1;
        valid_i = v; data_i = d; len_i = l; cancel_i = c; ip_cs_err_i = e;
    endtask

    int h3_cyc, p0_cyc, last_cyc, ca_cyc;

    task automatic send_pkt(input logic [15:0] dst, input logic [15:0] ln, input int npay,
                            input int cancel_at, input int err_at, input logic last_len);
        logic [15:0] d;
        int total;
        pkt_id++;
        total = 4 + npay;
        for (int j = 0; j < total; j++) begin
            if (j == 0)      d = 16'h3412;
            else if (j == 1) d = {dst[7:0], dst[15:8]};
            else if (j == 2) d = {ln[7:0], ln[15:8]};
            else if (j == 3) d = 16'h0000;
            else             d = 16'hBBAA + 16'((j - 4) * 16'h2222);
            drive(1'b1, d, (j == total - 1) ? last_len : 1'b0, j == cancel_at, j == err_at);
            if (j == 3) h3_cyc = cyc;
            if (j == 4) p0_cyc = cyc;
            if (j == cancel_at) ca_cyc = cyc;
            last_cyc = cyc;
        end
        for (int k = 0; k < 5; k++) drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        both_cnt = 0;
        #12;
        check("reset_outputs", {valid_o, cancel_o, miss_o, len_o, data_o}, '0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        nreset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // 1: channel 1, two payload beats
        send_pkt(16'd6000, 16'd12, 2, -1, -1, 1'b0);
        check("t1_vcnt", v_cnt, 2);
        check("t1_vch", v_ch, 2'b10);
        check("t1_first", v_first, p0_cyc + 1);
        check("t1_d0", mdata[0], 16'hBBAA);
        check("t1_d1", mdata[1], 16'hDDCC);
        check("t1_len", {mlen[0], mlen[1]}, 2'b00);
        check("t1_cancel", c_cnt, 0);
        check("t1_miss", m_cnt, 0);

        // 2: no port match
        send_pkt(16'd7000, 16'd12, 2, -1, -1, 1'b0);
        check("t2_miss", m_cnt, 1);
        check("t2_miss_cyc", m_cyc, h3_cyc + 1);
        check("t2_vcnt", v_cnt, 0);
        check("t2_cancel", c_cnt, 0);

        // 3: odd length, partial last beat
        send_pkt(16'd5000, 16'd13, 3, -1, -1, 1'b1);
        check("t3_vcnt", v_cnt, 3);
        check("t3_vch", v_ch, 2'b01);
        check("t3_len0", mlen[0], 1'b0);
        check("t3_len2", mlen[2], 1'b1);
        check("t3_d2", mdata[2], 16'hFFEE);
        check("t3_cancel", c_cnt, 0);

        // 4: padding beat suppressed
        send_pkt(16'd5000, 16'd10, 2, -1, -1, 1'b0);
        check("t4_vcnt", v_cnt, 1);
        check("t4_len0", mlen[0], 1'b0);
        check("t4_cancel", c_cnt, 0);

        // 5: short packet
        send_pkt(16'd5000, 16'd20, 2, -1, -1, 1'b0);
        check("t5_vcnt", v_cnt, 2);
        check("t5_cancel", c_cnt, 1);
        check("t5_cval", c_val, 2'b01);
        check("t5_ccyc", c_cyc, last_cyc + 2);

        // 6: cancel_i on payload beat 2
        send_pkt(16'd5000, 16'd16, 4, 5, -1, 1'b0);
        check("t6_vcnt", v_cnt, 1);
        check("t6_cancel", c_cnt, 1);
        check("t6_cval", c_val, 2'b01);
        check("t6_ccyc", c_cyc, ca_cyc + 1);

        // 7: checksum error during header beat 1
        send_pkt(16'd5000, 16'd16, 4, -1, 1, 1'b0);
        check("t7_vcnt", v_cnt, 4);
        check("t7_len3", mlen[3], 1'b0);
        check("t7_cancel", c_cnt, 1);
        check("t7_ccyc", c_cyc, last_cyc + 2);

        // cancel_i with ip_cs_err_i on the same beat: one pulse
        send_pkt(16'd6000, 16'd16, 4, 5, 5, 1'b0);
        check("tx_cancel_once", c_cnt, 1);
        check("tx_cval", c_val, 2'b10);

        // cancel_i on the first payload beat: nothing emitted, silent drop
        send_pkt(16'd5000, 16'd16, 4, 4, -1, 1'b0);
        check("tx_silent_v", v_cnt, 0);
        check("tx_silent_c", c_cnt, 0);

        // length 8 with a match: nothing emitted, no miss
        send_pkt(16'd5000, 16'd8, 1, -1, -1, 1'b0);
        check("tx_len8", {v_cnt[7:0], c_cnt[7:0], m_cnt[7:0]}, 24'h0);

        // length below 8: error, silent
        send_pkt(16'd5000, 16'd6, 1, -1, -1, 1'b0);
        check("tx_lenlt8", {v_cnt[7:0], c_cnt[7:0], m_cnt[7:0]}, 24'h0);

        check("no_valid_cancel_overlap", both_cnt, 0);

        // 8: reset during payload
        pkt_id++;
        drive(1'b1, 16'h3412, 1'b0, 1'b0, 1'b0);
        drive(1'b1, {8'h88, 8'h13}, 1'b0, 1'b0, 1'b0);
        drive(1'b1, {8'd20, 8'd0}, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        check("t8_pre_valid", valid_o, 2'b01);
        check("t8_pre_data", data_o, 16'h2222);
        nreset = 1'b0;
        #1;
        check("t8_reset_outputs", {valid_o, cancel_o, miss_o, len_o, data_o}, '0);
        valid_i = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        nreset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        send_pkt(16'd6000, 16'd12, 2, -1, -1, 1'b0);
        check("t8_after_vcnt", v_cnt, 2);
        check("t8_after_d0", mdata[0], 16'hBBAA);
        check("t8_after_cancel", c_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_rx_dispatch.md
# udp_rx_dispatch

Receive-side UDP transport stage with multi-channel dispatch. It consumes the payload stream delivered by `ipv4_rx` and parses the 8-byte UDP header. It matches the destination port against `CH_N` configured ports and steers the payload to the matching channel, suppressing Ethernet padding past the UDP length. It converts framing, length and upstream errors into per-channel cancel pulses, and replaces the single-port UDP receiver between `ipv4_rx` and the application.

## Interface
Parameters:
- `DATA_W`, 16, stream width; legal values are 16, 32 and 64.
- `KEEP_W`, `DATA_W/8`, bytes per beat.
- `LEN_W`, `$clog2(KEEP_W)`, width of the byte-count field.
- `CH_N`, 2, number of output channels, 1..8.
- `PORT_W`, 16, UDP port width.
- `PORTS`, `{16'd6000,16'd5000}`, `CH_N*PORT_W` packed destination ports; channel i is `PORTS[i*PORT_W +: PORT_W]`.

Ports:
- `clk`  in  1  clock.
- `nreset`  in  1  asynchronous reset, active low.
- `valid_i`  in  1  input beat valid; one packet is one contiguous run of valid beats, with at least 1 idle cycle between packets.
- `cancel_i`  in  1  upstream abort of the current packet.
- `data_i`  in  `DATA_W`  beat data; `data_i[7:0]` is the first byte on the wire.
- `len_i`  in  `LEN_W`  valid bytes on the beat; 0 means all `KEEP_W` bytes; non-zero only on a packet's last beat.
- `ip_cs_err_i`  in  1  IPv4 header checksum error for the current packet; may pulse on any cycle of the packet.
- `valid_o`  out  `CH_N`  one-hot payload valid.
- `data_o`  out  `DATA_W`  payload data, shared by all channels.
- `len_o`  out  `LEN_W`  payload byte count, same encoding as `len_i`.
- `cancel_o`  out  `CH_N`  one-cycle pulse: discard the channel's current packet.
- `miss_o`  out  1  one-cycle pulse: no port matched, packet dropped.

## Operation
- **Header parse.** The header occupies `HDR_BEATS = 8/KEEP_W` whole beats, so the payload starts beat-aligned and needs no realignment. Header bytes b0..b7 are assigned as follows (big-endian fields):
  - src port = {b0,b1}, ignored.
  - dst port = {b2,b3}.
  - length = {b4,b5}.
  - checksum = {b6,b7}, ignored.
- **Match.** dst port is compared against all `PORTS`; the lowest matching index wins. If nothing matches, `miss_o` pulses and the rest of the packet is dropped.
- **Payload counter.** A 16-bit `remain` is loaded with `length-8`.
  - While `remain > KEEP_W`, each payload beat is forwarded with `len_o=0` and `remain` is decremented by `KEEP_W`.
  - The beat on which `remain ≤ KEEP_W` is the final payload beat: `len_o = remain mod KEEP_W`.
  - Later beats (Ethernet padding) are suppressed.
- **Received-byte counter.** A second counter tracks received payload bytes using `len_i`.
- **FSM.** `IDLE`, `HDR`, `PAYLOAD`, `DRAIN`.
  - `IDLE`: on `valid_i` go to `HDR`; that beat is header beat 0.
  - `HDR`: after the last header beat, go to `PAYLOAD` if there is a match and `length>8`.
    - `length==8` with a match: go to `DRAIN` (nothing emitted).
    - `length<8`: go to `DRAIN` as an error.
    - No match: go to `DRAIN` and pulse `miss_o`.
  - `PAYLOAD`: after the final payload beat, go to `DRAIN`.
  - `DRAIN`: consume beats without output.
  - Any state: `valid_i` low ends the packet; go to `IDLE`.
- **Error set** (sticky per packet, cleared in `IDLE`):
  - `ip_cs_err_i` seen.
  - `cancel_i` seen.
  - `length<8`.
  - Packet ends with received payload bytes < `length-8` (short).
- **Cancel rule.** `cancel_o[ch]` fires only if at least one `valid_o` beat was emitted for the packet; otherwise the packet is dropped silently.
- **`cancel_i`.**
  - The beat carrying `cancel_i` is discarded.
  - If the packet is in `PAYLOAD` with emitted beats, `cancel_o` pulses the next cycle.
  - The FSM goes to `DRAIN`; only one cancel is issued per packet.
  - `cancel_i` is ignored in `IDLE`.
- **End-of-packet errors.** `ip_cs_err_i` and the short condition are evaluated at packet end (cycle E, the first cycle with `valid_i` low). `cancel_o` is issued in cycle E+1.
- **Reset mid-packet.** Asynchronous reset clears all state immediately. The first `valid_i` after release is parsed as a header; upstream must hold `valid_i` low until a packet boundary.

## Timing
- Reset values: `valid_o=0`, `cancel_o=0`, `miss_o=0`, `data_o=0`, `len_o=0`, FSM=`IDLE`.
- All outputs are registered.
- A payload beat at input cycle t appears on `valid_o`/`data_o` at t+1.
- `miss_o` fires in the cycle after the last header beat.
- Cancel timing:
  - From `cancel_i`: one cycle after it is sampled.
  - From end-of-packet errors: cycle E+1 = last input beat + 2.
  - Consumers commit a packet only after cycle E+1 passes without `cancel_o`.
- Simultaneous events:
  - `cancel_i` together with the final payload beat: the beat is not emitted; cancel is issued if earlier beats were emitted.
  - `ip_cs_err_i` together with `cancel_i`: a single cancel pulse.
- Throughput: 1 beat per cycle, no backpressure.
- `valid_o` and `cancel_o` never assert on the same cycle.

## Test plan
All scenarios use `DATA_W=16`, `CH_N=2`, `PORTS={6000,5000}`.
1. dst=6000, length=12, payload beats 0xBBAA, 0xDDCC → `valid_o=2'b10` for 2 cycles starting 1 cycle after the first payload beat, `len_o=0`, no cancel, no miss.
2. dst=7000, length=12 → `miss_o` pulses once, 1 cycle after header beat 3; `valid_o` stays 0.
3. dst=5000, length=13, 3 payload beats, last beat `len_i=1` → `valid_o[0]` for 3 beats, last `len_o=1`.
4. dst=5000, length=10, 2 input payload beats (second is padding) → 1 `valid_o` beat; second suppressed; no cancel.
5. dst=5000, length=20, `valid_i` drops after 2 payload beats → 2 `valid_o` beats, then `cancel_o[0]` at E+1.
6. `cancel_i` on payload beat 2 of a length=16 packet → beat 1 emitted, `cancel_o` pulses the next cycle, rest ignored.
7. Repeat of 6 with `ip_cs_err_i` pulsed during header beat 1 instead of `cancel_i` → beats emitted, cancel at E+1.
8. Reset asserted mid-payload → all outputs drop to 0 within the same cycle.
